parking_occupancy_tracker: RTL and testbench
============================================

# parking_occupancy_tracker

Parametrised, clocked occupancy tracker for the smart parking system. On request it captures the slot-sensor vector and counts occupied slots serially, SLICE bits per cycle. It then publishes parked and free counts, full and empty flags, and optional arrival/departure event totals to the display and gate logic. It sits between the slot sensors and the capacity/gate controllers, replacing the fixed 8-bit combinational count.

## Interface
- SLOTS, 8, number of parking slots (1..255)
- SLICE, 4, slots counted per scan cycle (1..SLOTS)
- EVT_W, 8, width of arrival/departure event counters
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- slot_sense  in  SLOTS  1 = slot occupied
- start  in  1  scan request, sampled only in IDLE
- clear_events  in  1  synchronous clear of the event counters
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse when results update
- parked  out  CNT_W  occupied slots, where CNT_W = $clog2(SLOTS+1)
- free_slots  out  CNT_W  SLOTS − parked
- full  out  1  parked == SLOTS
- empty  out  1  parked == 0
- arrivals  out  EVT_W  saturating count of 0→1 slot transitions (macro-gated)
- departures  out  EVT_W  saturating count of 1→0 slot transitions (macro-gated)

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, start=1:
  - capture slot_sense into snap
  - zero slice index and accumulators
  - go to SCAN
- SCAN, each cycle:
  - acc += popcount(snap slice)
  - arr_acc += popcount(snap slice & ~prev slice)
  - dep_acc += popcount(~snap slice & prev slice)
  - index += 1
  - after PASSES = ceil(SLOTS/SLICE) cycles, go to DONE
- The final partial slice zero-pads bits at or above SLOTS.
- DONE, one cycle:
  - parked <= acc; free_slots <= SLOTS − acc
  - full/empty <= derived from acc
  - prev <= snap
  - event counters update
  - done=1
  - go to IDLE
- start is ignored while busy. No queuing.
- slot_sense changes during SCAN have no effect; snap is frozen.
- Event counters:
  - add arr_acc/dep_acc in DONE, saturating at 2^EVT_W−1
  - clear_events in any state zeroes both counters
  - if clear_events coincides with DONE, clear wins and that scan's increments are discarded
  - prev still updates
- prev resets to 0, so the first scan after reset counts every occupied slot as an arrival.
- Internal accumulators are CNT_W wide and cannot overflow.

## Timing
- Reset values:
  - parked=0, free_slots=SLOTS, full=0, empty=1
  - arrivals=0, departures=0, busy=0, done=0
  - state=IDLE, snap=0, prev=0
- start sampled high at edge 0 → done high in the cycle after edge PASSES+1. Outputs are valid from that cycle and held until the next DONE.
- busy rises the cycle after start is sampled and falls together with done.
- The earliest back-to-back start is accepted in the cycle after done (IDLE). Scan period = PASSES+2 cycles.
- rst_n assertion mid-scan aborts immediately. Outputs return to reset values and partial results are discarded.

## Configuration
- PARKING_EVENT_CNT_EN defined:
  - prev register, arr/dep accumulators and arrivals/departures counters are built
  - clear_events is functional
- PARKING_EVENT_CNT_EN undefined:
  - arrivals/departures are tied to 0
  - clear_events is ignored
  - no prev/event logic is synthesised
  - parked/free/full/empty timing is unchanged

## Structure
- parking_pkg holds:
  - state encoding constants (IDLE, SCAN, DONE)
  - a CNT_W helper function
  - the PASSES computation function
- One sub-module, slice_ones_counter (parameter SLICE): combinational popcount of a SLICE-bit vector with a $clog2(SLICE+1)-bit result. It is instantiated three times: occupancy, arrival mask, departure mask.

## Test plan
Defaults unless stated (SLOTS=8, SLICE=4, PASSES=2).
- Reset, then slot_sense=8'b1011_0001, start pulse:
  - done in the cycle after edge 3
  - parked=4, free_slots=4, arrivals=4, departures=0
- slot_sense=8'hFF scan → full=1, empty=0, free_slots=0. Then slot_sense=8'h00 scan → parked=0, empty=1, departures=8.
- SLOTS=10, SLICE=4 (PASSES=3), slot_sense=10'b11_0000_0001:
  - parked=3
  - done in the cycle after edge 4 (padding bits ignored)
- Toggle slot_sense and pulse start during SCAN:
  - result reflects the captured snapshot only
  - the extra start is ignored; exactly one done
- EVT_W=2, alternate 8'h01/8'h00 scans five times → arrivals saturates at 3. clear_events asserted in the DONE cycle → arrivals=0, departures=0.
- rst_n low for one cycle mid-SCAN → all outputs at reset values, busy=0. A following scan of 8'h0F gives parked=4 and arrivals=4.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared state encoding and sizing helpers for the parking occupancy tracker.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width needed to hold a count of 0..slots inclusive.
    function automatic int cnt_w(input int slots);
        return $clog2(slots + 1);
    endfunction

    function automatic int passes(input int slots, input int slice);
        return (slots + slice - 1) / slice;
    endfunction

endpackage

// File: rtl/slice_ones_counter.sv
// Combinational population count of one SLICE-bit scan slice.
module slice_ones_counter #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0]           vec_i,
    output logic [$clog2(SLICE+1)-1:0] cnt_o
);

    localparam int CW = $clog2(SLICE + 1);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < SLICE; i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Serial slot-occupancy counter with published parked/free/full/empty results.
// Arrival/departure event totals are built only with PARKING_EVENT_CNT_EN defined.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int SLOTS = 8,
    parameter int SLICE = 4,
    parameter int EVT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SLOTS-1:0]           slot_sense,
    input  logic                       start,
    input  logic                       clear_events,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(SLOTS+1)-1:0] parked,
    output logic [$clog2(SLOTS+1)-1:0] free_slots,
    output logic                       full,
    output logic                       empty,
    output logic [EVT_W-1:0]           arrivals,
    output logic [EVT_W-1:0]           departures
);

    localparam int CNT_W  = cnt_w(SLOTS);
    localparam int PASSES = passes(SLOTS, SLICE);
    localparam int IDX_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int PW     = $clog2(SLICE + 1);
    // Padded to every index value so the slice select never leaves the vector.
    localparam int PAD_W  = SLICE << IDX_W;

    state_e state_q, state_d;
    logic   load_en, scan_en, publish_en;

    logic [SLOTS-1:0] snap_q, snap_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [PAD_W-1:0] snap_pad;
    logic [SLICE-1:0] occ_slice;
    logic [PW-1:0]    occ_cnt;

    logic [CNT_W-1:0] parked_q, free_q;
    logic             full_q, empty_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_SCAN;
            ST_SCAN: if (idx_q == IDX_W'(PASSES - 1)) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != ST_IDLE);
        load_en    = (state_q == ST_IDLE) && start;
        scan_en    = (state_q == ST_SCAN);
        publish_en = (state_q == ST_DONE);
    end

    always_comb begin
        snap_pad              = '0;
        snap_pad[SLOTS-1:0]   = snap_q;
    end

    assign occ_slice = snap_pad[idx_q*SLICE +: SLICE];

    slice_ones_counter #(.SLICE(SLICE)) u_occ_cnt (
        .vec_i (occ_slice),
        .cnt_o (occ_cnt)
    );

    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        acc_d  = acc_q;
        if (load_en) begin
            snap_d = slot_sense;
            idx_d  = '0;
            acc_d  = '0;
        end else if (scan_en) begin
            idx_d = idx_q + 1'b1;
            acc_d = acc_q + CNT_W'(occ_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q   <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            parked_q <= '0;
            free_q   <= CNT_W'(SLOTS);
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            acc_q  <= acc_d;
            done_q <= publish_en;
            if (publish_en) begin
                parked_q <= acc_q;
                free_q   <= CNT_W'(SLOTS) - acc_q;
                full_q   <= (acc_q == CNT_W'(SLOTS));
                empty_q  <= (acc_q == '0);
            end
        end
    end

    assign parked     = parked_q;
    assign free_slots = free_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign done       = done_q;

`ifdef PARKING_EVENT_CNT_EN
    localparam int SUM_W = ((EVT_W > CNT_W) ? EVT_W : CNT_W) + 1;
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [SLOTS-1:0] prev_q;
    logic [PAD_W-1:0] prev_pad;
    logic [SLICE-1:0] prev_slice, arr_mask, dep_mask;
    logic [PW-1:0]    arr_cnt, dep_cnt;
    logic [CNT_W-1:0] arr_acc_q, arr_acc_d, dep_acc_q, dep_acc_d;
    logic [EVT_W-1:0] arr_tot_q, arr_tot_d, dep_tot_q, dep_tot_d;

    function automatic logic [EVT_W-1:0] sat_add(input logic [EVT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'(EVT_MAX)) ? EVT_MAX : s[EVT_W-1:0];
    endfunction

    always_comb begin
        prev_pad            = '0;
        prev_pad[SLOTS-1:0] = prev_q;
    end

    assign prev_slice = prev_pad[idx_q*SLICE +: SLICE];
    assign arr_mask   = occ_slice & ~prev_slice;
    assign dep_mask   = ~occ_slice & prev_slice;

    slice_ones_counter #(.SLICE(SLICE)) u_arr_cnt (
        .vec_i (arr_mask),
        .cnt_o (arr_cnt)
    );

    slice_ones_counter #(.SLICE(SLICE)) u_dep_cnt (
        .vec_i (dep_mask),
        .cnt_o (dep_cnt)
    );

    always_comb begin
        arr_acc_d = arr_acc_q;
        dep_acc_d = dep_acc_q;
        arr_tot_d = arr_tot_q;
        dep_tot_d = dep_tot_q;
        if (load_en) begin
            arr_acc_d = '0;
            dep_acc_d = '0;
        end else if (scan_en) begin
            arr_acc_d = arr_acc_q + CNT_W'(arr_cnt);
            dep_acc_d = dep_acc_q + CNT_W'(dep_cnt);
        end
        // A clear coinciding with publish drops that scan's increments.
        if (clear_events) begin
            arr_tot_d = '0;
            dep_tot_d = '0;
        end else if (publish_en) begin
            arr_tot_d = sat_add(arr_tot_q, arr_acc_q);
            dep_tot_d = sat_add(dep_tot_q, dep_acc_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            arr_acc_q <= '0;
            dep_acc_q <= '0;
            arr_tot_q <= '0;
            dep_tot_q <= '0;
        end else begin
            arr_acc_q <= arr_acc_d;
            dep_acc_q <= dep_acc_d;
            arr_tot_q <= arr_tot_d;
            dep_tot_q <= dep_tot_d;
            if (publish_en) prev_q <= snap_q;
        end
    end

    assign arrivals   = arr_tot_q;
    assign departures = dep_tot_q;
`else
    logic evt_unused;
    assign evt_unused = clear_events;
    assign arrivals   = '0;
    assign departures = '0;
`endif

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Directed bench for parking_occupancy_tracker: three instances cover default,
// SLOTS=10 padding and EVT_W=2 saturation; event expectations follow PARKING_EVENT_CNT_EN.
module tb_parking_occupancy_tracker;

`ifdef PARKING_EVENT_CNT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: SLOTS=8 SLICE=4 EVT_W=8
    logic [7:0] sense_a = '0;
    logic       start_a = 0, clr_a = 0, busy_a, done_a, full_a, empty_a;
    logic [3:0] parked_a, free_a;
    logic [7:0] arr_a, dep_a;
    // B: SLOTS=10 SLICE=4
    logic [9:0] sense_b = '0;
    logic       start_b = 0, clr_b = 0, busy_b, done_b, full_b, empty_b;
    logic [3:0] parked_b, free_b;
    logic [7:0] arr_b, dep_b;
    // C: SLOTS=8 SLICE=4 EVT_W=2
    logic [7:0] sense_c = '0;
    logic       start_c = 0, clr_c = 0, busy_c, done_c, full_c, empty_c;
    logic [3:0] parked_c, free_c;
    logic [1:0] arr_c, dep_c;

    parking_occupancy_tracker #(.SLOTS(8), .SLICE(4), .EVT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .slot_sense(sense_a), .start(start_a),
        .clear_events(clr_a), .busy(busy_a), .done(done_a), .parked(parked_a),
        .free_slots(free_a), .full(full_a), .empty(empty_a),
        .arrivals(arr_a), .departures(dep_a));

    parking_occupancy_tracker #(.SLOTS(10), .SLICE(4), .EVT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .slot_sense(sense_b), .start(start_b),
        .clear_events(clr_b), .busy(busy_b), .done(done_b), .parked(parked_b),
        .free_slots(free_b), .full(full_b), .empty(empty_b),
        .arrivals(arr_b), .departures(dep_b));

    parking_occupancy_tracker #(.SLOTS(8), .SLICE(4), .EVT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .slot_sense(sense_c), .start(start_c),
        .clear_events(clr_c), .busy(busy_c), .done(done_c), .parked(parked_c),
        .free_slots(free_c), .full(full_c), .empty(empty_c),
        .arrivals(arr_c), .departures(dep_c));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ev(input int v);
        return EV ? v : 0;
    endfunction

    logic [2:0] dn;
    assign dn = {done_c, done_b, done_a};

    // Pulses start on one instance at edge 0 and returns the edge after which done is seen.
    task automatic scan(input int sel, input logic [9:0] val, output int lat);
        @(negedge clk);
        case (sel)
            0: begin sense_a = val[7:0]; start_a = 1'b1; end
            1: begin sense_b = val;      start_b = 1'b1; end
            default: begin sense_c = val[7:0]; start_c = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(negedge clk);
            if (dn[sel]) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int nd;

        repeat (3) @(negedge clk);
        chk("rst_parked", parked_a, 0);
        chk("rst_free", free_a, 8);
        chk("rst_free_b", free_b, 10);
        chk("rst_full", full_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_arr", arr_a, 0);
        chk("rst_dep", dep_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        rst_n = 1'b1;

        // First scan: every occupied slot is an arrival.
        scan(0, 10'h0B1, lat);
        chk("lat_a", lat, 3);
        chk("b1_parked", parked_a, 4);
        chk("b1_free", free_a, 4);
        chk("b1_arr", arr_a, ev(4));
        chk("b1_dep", dep_a, 0);
        chk("b1_empty", empty_a, 0);
        @(negedge clk);
        chk("done_pulse", done_a, 0);
        chk("hold_parked", parked_a, 4);

        scan(0, 10'h0FF, lat);
        chk("ff_full", full_a, 1);
        chk("ff_empty", empty_a, 0);
        chk("ff_free", free_a, 0);
        chk("ff_parked", parked_a, 8);
        chk("ff_arr", arr_a, ev(8));

        scan(0, 10'h000, lat);
        chk("00_parked", parked_a, 0);
        chk("00_empty", empty_a, 1);
        chk("00_full", full_a, 0);
        chk("00_dep", dep_a, ev(8));

        // Padding bits of the last partial slice are ignored.
        scan(1, 10'b11_0000_0001, lat);
        chk("lat_b", lat, 4);
        chk("b_parked", parked_b, 3);
        chk("b_free", free_b, 7);

        // Sense changes and extra starts during SCAN have no effect.
        @(negedge clk);
        sense_a = 8'h0F; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy_rise", busy_a, 1);
        sense_a = 8'hF0;
        @(negedge clk);
        sense_a = 8'hAA;
        @(negedge clk);
        start_a = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("snap_ndone", nd, 1);
        chk("snap_parked", parked_a, 4);
        chk("snap_arr", arr_a, ev(12));
        chk("snap_busy", busy_a, 0);

        // EVT_W=2 saturation: five arrivals and five departures.
        for (int k = 0; k < 5; k++) begin
            scan(2, 10'h001, lat);
            scan(2, 10'h000, lat);
        end
        chk("sat_arr", arr_c, ev(3));
        chk("sat_dep", dep_c, ev(3));

        // Clear in the DONE cycle wins; results and prev still update.
        @(negedge clk);
        sense_c = 8'h01; start_c = 1'b1;
        @(posedge clk);
        @(negedge clk); start_c = 1'b0;
        @(negedge clk);
        @(negedge clk); clr_c = 1'b1;
        @(negedge clk); clr_c = 1'b0;
        chk("clr_done", done_c, 1);
        chk("clr_arr", arr_c, 0);
        chk("clr_dep", dep_c, 0);
        chk("clr_parked", parked_c, 1);
        scan(2, 10'h000, lat);
        chk("clr_prev_dep", dep_c, ev(1));
        chk("clr_prev_arr", arr_c, 0);

        // Reset mid-SCAN aborts and restores reset values.
        @(negedge clk);
        sense_a = 8'hFF; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("mid_parked", parked_a, 0);
        chk("mid_free", free_a, 8);
        chk("mid_empty", empty_a, 1);
        chk("mid_arr", arr_a, 0);
        chk("mid_dep", dep_a, 0);
        chk("mid_busy", busy_a, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a) nd++;
        end
        chk("mid_nodone", nd, 0);
        scan(0, 10'h00F, lat);
        chk("post_lat", lat, 3);
        chk("post_parked", parked_a, 4);
        chk("post_arr", arr_a, ev(4));
        chk("post_dep", dep_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
